mem_resp_stage: RTL and testbench



---
 rtl/mem_resp_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_resp_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_stage.sv
// Memory-response pipeline stage: registers the instruction from the memory-request
// stage, waits for load data, aligns/extends it, and drops responses of flushed loads.
module mem_resp_stage #(
  parameter int PC_W      = 32,
  parameter int EX_W      = 6,
  parameter int DEST_W    = 5,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_allow,
  output logic              out_valid,
  input  logic              out_allow,
  input  logic              flush,
  input  logic [EX_W-1:0]   in_ex,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_reg_we,
  input  logic              in_load_op,
  input  logic [4:0]        in_load_type,
  input  logic [1:0]        in_offset,
  input  logic [31:0]       in_mem_value,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [EX_W-1:0]   out_ex,
  output logic [PC_W-1:0]   out_pc,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_reg_we,
  output logic [31:0]       out_wb_value,
  output logic              load_pending
);
  // state   | meaning
  // S_EMPTY | no instruction held
  // S_WAIT  | load held, read data not yet returned
  // S_READY | instruction complete, presented to writeback
  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_e;

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int CW2   = CNT_W + 2;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EX_W-1:0]     ex_q, ex_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic                reg_we_q, reg_we_d;
  logic                load_q, load_d;
  logic [4:0]          type_q, type_d;
  logic [1:0]          offset_q, offset_d;
  logic [31:0]         mem_value_q, mem_value_d;
  logic [31:0]         data_q, data_d;

  logic                is_load, accept, cnt_zero, take, drop, inc_wait, inc_new;
  logic [CW2-1:0]      cnt_full;

  always_comb begin
    state_d     = state_q;
    ex_d        = ex_q;
    pc_d        = pc_q;
    dest_d      = dest_q;
    reg_we_d    = reg_we_q;
    load_d      = load_q;
    type_d      = type_q;
    offset_d    = offset_q;
    mem_value_d = mem_value_q;
    data_d      = data_q;

    is_load  = in_load_op && (in_ex == '0);
    in_allow = (state_q == S_EMPTY) || ((state_q == S_READY) && out_allow);
    accept   = in_valid && in_allow && !flush;
    cnt_zero = (cnt_q == '0);
    // A response belongs to an orphaned request first; only with none left is it ours.
    take     = data_data_ok && cnt_zero;
    drop     = data_data_ok && !cnt_zero;
    inc_wait = flush && (state_q == S_WAIT) && !take;
    inc_new  = flush && in_valid && is_load;

    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      if ((state_q == S_WAIT) && take) begin
        state_d = S_READY;
        data_d  = data_rdata;
      end
      if ((state_q == S_READY) && out_allow) state_d = S_EMPTY;
      if (accept) begin
        ex_d        = in_ex;
        pc_d        = in_pc;
        dest_d      = in_dest;
        reg_we_d    = in_reg_we;
        load_d      = in_load_op;
        type_d      = in_load_type;
        offset_d    = in_offset;
        mem_value_d = in_mem_value;
        if (is_load && !take) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_READY;
          if (is_load) data_d = data_rdata;
        end
      end
    end

    cnt_full = CW2'(cnt_q) + CW2'(inc_wait) + CW2'(inc_new) - CW2'(drop);
    if (cnt_full > CW2'(MAX_OUTST)) cnt_d = CNT_W'(MAX_OUTST);
    else                            cnt_d = cnt_full[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_EMPTY;
      cnt_q       <= '0;
      ex_q        <= '0;
      pc_q        <= '0;
      dest_q      <= '0;
      reg_we_q    <= 1'b0;
      load_q      <= 1'b0;
      type_q      <= '0;
      offset_q    <= '0;
      mem_value_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_q        <= ex_d;
      pc_q        <= pc_d;
      dest_q      <= dest_d;
      reg_we_q    <= reg_we_d;
      load_q      <= load_d;
      type_q      <= type_d;
      offset_q    <= offset_d;
      mem_value_q <= mem_value_d;
      data_q      <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      a_outst_bound: assert (cnt_full <= CW2'(MAX_OUTST));
    end
  end

  logic [31:0] byte_sh;
  logic [15:0] half_v;

  always_comb begin
    byte_sh      = data_q >> {offset_q, 3'b000};
    half_v       = offset_q[1] ? data_q[31:16] : data_q[15:0];
    out_wb_value = mem_value_q;
    if (load_q && (ex_q == '0)) begin
      if (type_q[4])      out_wb_value = data_q;
      else if (type_q[3]) out_wb_value = {16'h0000, half_v};
      else if (type_q[2]) out_wb_value = {{16{half_v[15]}}, half_v};
      else if (type_q[1]) out_wb_value = {24'h000000, byte_sh[7:0]};
      else if (type_q[0]) out_wb_value = {{24{byte_sh[7]}}, byte_sh[7:0]};
      else                out_wb_value = data_q;
    end
  end

  assign out_valid    = (state_q == S_READY);
  assign load_pending = (state_q == S_WAIT);
  assign out_ex       = ex_q;
  assign out_pc       = pc_q;
  assign out_dest     = dest_q;
  assign out_reg_we   = reg_we_q && (ex_q == '0);

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage: throughput, load alignment, same-cycle data,
// flush orphan accounting, excepted loads and output hold.
module tb_mem_resp_stage;
  localparam logic [4:0] LB  = 5'b00001;
  localparam logic [4:0] LBU = 5'b00010;
  localparam logic [4:0] LH  = 5'b00100;
  localparam logic [4:0] LHU = 5'b01000;
  localparam logic [4:0] LW  = 5'b10000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_allow, out_valid, out_allow, flush;
  logic [5:0]  in_ex, out_ex;
  logic [31:0] in_pc, out_pc;
  logic [4:0]  in_dest, out_dest;
  logic        in_reg_we, out_reg_we, in_load_op;
  logic [4:0]  in_load_type;
  logic [1:0]  in_offset;
  logic [31:0] in_mem_value, data_rdata, out_wb_value;
  logic        data_data_ok, load_pending;

  int n_checks = 0;
  int n_errors = 0;

  mem_resp_stage #(.PC_W(32), .EX_W(6), .DEST_W(5), .MAX_OUTST(2)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_allow(in_allow),
    .out_valid(out_valid), .out_allow(out_allow), .flush(flush),
    .in_ex(in_ex), .in_pc(in_pc), .in_dest(in_dest), .in_reg_we(in_reg_we),
    .in_load_op(in_load_op), .in_load_type(in_load_type), .in_offset(in_offset),
    .in_mem_value(in_mem_value), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .out_ex(out_ex), .out_pc(out_pc), .out_dest(out_dest), .out_reg_we(out_reg_we),
    .out_wb_value(out_wb_value), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    flush        = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    in_load_op   = 1'b0;
    in_load_type = 5'b0;
    in_offset    = 2'b0;
    in_ex        = 6'h0;
    in_pc        = 32'h0;
    in_dest      = 5'h0;
    in_reg_we    = 1'b0;
    in_mem_value = 32'h0;
    out_allow    = 1'b1;
  endtask

  task automatic present_load(input logic [4:0] lt, input logic [1:0] off);
    in_valid     = 1'b1;
    in_load_op   = 1'b1;
    in_load_type = lt;
    in_offset    = off;
    in_ex        = 6'h0;
    in_reg_we    = 1'b1;
    in_mem_value = 32'h0BAD_0BAD;
  endtask

  // Load accepted, data returns on the third edge after accept.
  task automatic do_load(input string tag, input logic [4:0] lt, input logic [1:0] off,
                         input logic [31:0] rdata, input logic [31:0] exp);
    present_load(lt, off);
    step();
    in_valid   = 1'b0;
    in_load_op = 1'b0;
    check({tag, "_pend0"}, 32'(load_pending), 32'd1);
    for (int i = 1; i < 3; i++) begin
      step();
      check({tag, "_pend"}, 32'(load_pending), 32'd1);
      check({tag, "_nov"}, 32'(out_valid), 32'd0);
    end
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    step();
    data_data_ok = 1'b0;
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check({tag, "_pend_clr"}, 32'(load_pending), 32'd0);
    check({tag, "_wb"}, out_wb_value, exp);
    step();
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    resetn = 1'b0;
    step();
    step();
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_ia", 32'(in_allow), 32'd1);
    check("rst_lp", 32'(load_pending), 32'd0);
    check("rst_wb", out_wb_value, 32'h0);
    check("rst_cnt", 32'(dut.cnt_q), 32'd0);
    resetn = 1'b1;
    step();

    // back-to-back non-load
    in_valid = 1'b1; in_mem_value = 32'h1234; in_reg_we = 1'b1; in_pc = 32'h100; in_dest = 5'd3;
    step();
    check("add0_ov", 32'(out_valid), 32'd1);
    check("add0_wb", out_wb_value, 32'h1234);
    check("add0_ia", 32'(in_allow), 32'd1);
    check("add0_we", 32'(out_reg_we), 32'd1);
    check("add0_pc", out_pc, 32'h100);
    check("add0_dst", 32'(out_dest), 32'd3);
    in_mem_value = 32'h5678; in_pc = 32'h104;
    step();
    check("add1_ov", 32'(out_valid), 32'd1);
    check("add1_wb", out_wb_value, 32'h5678);
    check("add1_pc", out_pc, 32'h104);
    idle();
    step();
    check("add_drain", 32'(out_valid), 32'd0);

    do_load("lb",  LB,  2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", LBU, 2'd3, 32'h80FF_0000, 32'h0000_0080);
    do_load("lhu", LHU, 2'd2, 32'h80FF_0000, 32'h0000_80FF);
    do_load("lh",  LH,  2'd0, 32'h1234_8001, 32'hFFFF_8001);
    do_load("lb1", LB,  2'd1, 32'h0000_7F00, 32'h0000_007F);

    // same-cycle data: no wait state
    present_load(LW, 2'd0);
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    step();
    idle();
    check("lw0_ov", 32'(out_valid), 32'd1);
    check("lw0_lp", 32'(load_pending), 32'd0);
    check("lw0_wb", out_wb_value, 32'hDEAD_BEEF);
    step();

    // flush a waiting load, its response is dropped
    present_load(LW, 2'd0);
    step();
    idle();
    check("fl1_lp", 32'(load_pending), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl1_ov", 32'(out_valid), 32'd0);
    check("fl1_lp2", 32'(load_pending), 32'd0);
    check("fl1_cnt", 32'(dut.cnt_q), 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
    step();
    data_data_ok = 1'b0;
    check("fl1_cnt0", 32'(dut.cnt_q), 32'd0);
    check("fl1_nov", 32'(out_valid), 32'd0);
    present_load(LW, 2'd0);
    step();
    idle();
    check("fl1_new_lp", 32'(load_pending), 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'h2222_2222;
    step();
    data_data_ok = 1'b0;
    check("fl1_new_ov", 32'(out_valid), 32'd1);
    check("fl1_new_wb", out_wb_value, 32'h2222_2222);
    step();

    // flush with waiting load plus a newly issued load: two orphans
    present_load(LW, 2'd0);
    step();
    check("fl2_lp", 32'(load_pending), 32'd1);
    flush = 1'b1;
    step();
    idle();
    check("fl2_cnt", 32'(dut.cnt_q), 32'd2);
    check("fl2_ov", 32'(out_valid), 32'd0);
    check("fl2_ia", 32'(in_allow), 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'h3333_3333;
    step();
    check("fl2_cnt1", 32'(dut.cnt_q), 32'd1);
    check("fl2_nov1", 32'(out_valid), 32'd0);
    data_rdata = 32'h4444_4444;
    step();
    data_data_ok = 1'b0;
    check("fl2_cnt0", 32'(dut.cnt_q), 32'd0);
    check("fl2_nov2", 32'(out_valid), 32'd0);
    present_load(LW, 2'd0);
    data_data_ok = 1'b1; data_rdata = 32'hAAAA_5555;
    step();
    idle();
    check("fl2_new_ov", 32'(out_valid), 32'd1);
    check("fl2_new_wb", out_wb_value, 32'hAAAA_5555);
    step();

    // excepted load: no wait, reg_we masked, then held under backpressure
    present_load(LW, 2'd0);
    in_ex = 6'h04; in_mem_value = 32'hCAFE_0000; in_pc = 32'h200;
    out_allow = 1'b0;
    step();
    check("ex_ov", 32'(out_valid), 32'd1);
    check("ex_lp", 32'(load_pending), 32'd0);
    check("ex_we", 32'(out_reg_we), 32'd0);
    check("ex_wb", out_wb_value, 32'hCAFE_0000);
    check("ex_ex", 32'(out_ex), 32'h04);
    in_load_op = 1'b0; in_ex = 6'h0; in_mem_value = 32'h0000_0001; in_pc = 32'h204;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hold_ia", 32'(in_allow), 32'd0);
      step();
      check("hold_ov", 32'(out_valid), 32'd1);
      check("hold_wb", out_wb_value, 32'hCAFE_0000);
      check("hold_pc", out_pc, 32'h200);
    end
    out_allow = 1'b1;
    #1;
    check("rel_ia", 32'(in_allow), 32'd1);
    step();
    idle();
    check("rel_ov", 32'(out_valid), 32'd1);
    check("rel_wb", out_wb_value, 32'h0000_0001);
    check("rel_we", 32'(out_reg_we), 32'd1);
    step();
    check("rel_drain", 32'(out_valid), 32'd0);

    // reset mid-operation clears the discard counter
    present_load(LW, 2'd0);
    step();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("mr_cnt1", 32'(dut.cnt_q), 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("mr_cnt0", 32'(dut.cnt_q), 32'd0);
    check("mr_ov", 32'(out_valid), 32'd0);
    present_load(LW, 2'd0);
    data_data_ok = 1'b1; data_rdata = 32'h5A5A_A5A5;
    step();
    idle();
    check("mr_wb", out_wb_value, 32'h5A5A_A5A5);
    check("mr_ov2", 32'(out_valid), 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
